// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory access unit.
package mem_pkg;

    localparam int ADDR_W_DEF    = 15;
    localparam int MEM_WORDS_DEF = 256;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // True when the access size is illegal or the byte lane breaks natural alignment.
    function automatic logic misaligned(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            SZ_WORD: misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extract/extend for loads, byte/half merge for stores.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        byte_v     = word[{lane, 3'b000} +: 8];
        half_v     = word[{lane[1], 4'b0000} +: 16];
        load_data  = word;
        merge_data = word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
                merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & half_v[15]}}, half_v};
                merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_data  = word;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port: request/response handshake, RMW for
// sub-word stores and extract/extend for sub-word loads.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    state_e      state;
    logic [1:0]  lane_q;
    size_e       size_q;
    logic        signed_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        req_error;

    // Out of range covers both address bits above the memory port and unimplemented words.
    assign req_error = misaligned(size_e'(req_size), req_addr[1:0])
                     || (req_addr[31:ADDR_W+2] != '0)
                     || ((req_addr >> 2) >= 32'(MEM_WORDS));

    mem_lane_align u_align (
        .word       (mem_read_data),
        .lane       (lane_q),
        .size       (size_q),
        .sign_ext   (signed_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_address    <= '0;
            mem_write_en   <= 1'b0;
            mem_write_data <= '0;
            lane_q         <= '0;
            size_q         <= SZ_BYTE;
            signed_q       <= 1'b0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        lane_q    <= req_addr[1:0];
                        size_q    <= size_e'(req_size);
                        signed_q  <= req_signed;
                        we_q      <= req_we;
                        wdata_q   <= req_wdata;
                        if (req_error) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else if (req_we && size_e'(req_size) == SZ_WORD) begin
                            mem_address    <= req_addr[ADDR_W+1:2];
                            mem_write_data <= req_wdata;
                            mem_write_en   <= 1'b1;
                            state          <= ST_WRITE;
                        end else begin
                            mem_address <= req_addr[ADDR_W+1:2];
                            state       <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (we_q) begin
                        mem_write_data <= merge_data;
                        mem_write_en   <= 1'b1;
                        state          <= ST_WRITE;
                    end else begin
                        resp_rdata <= load_data;
                        resp_error <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    // The memory write is level-sensitive: the strobe lasts exactly this one cycle.
                    mem_write_en <= 1'b0;
                    resp_rdata   <= '0;
                    resp_error   <= 1'b0;
                    resp_valid   <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expectations, a monitor checks responses.
module tb_mem_access_unit;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_error;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write_en;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    mem_access_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(256)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_writes = 0;
    logic [31:0] ram[256];
    logic        prev_we  = 1'b0;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    logic        seen     = 1'b0;
    logic [31:0] held_rdata;
    logic        held_err;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    assign mem_read_data = (mem_address < 256) ? ram[mem_address[7:0]] : 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model plus single-cycle strobe watch.
    always @(posedge clk) begin
        if (mem_write_en) begin
            ram[mem_address[7:0]] <= mem_write_data;
            n_writes   <= n_writes + 1;
            last_waddr <= 32'(mem_address);
            last_wdata <= mem_write_data;
            check("we_single_cycle", 32'(prev_we), 32'd0);
        end
        prev_we <= mem_write_en;
    end

    // Response monitor.
    always @(negedge clk) begin
        if (resp_valid && !seen) begin
            seen = 1'b1;
            held_rdata = resp_rdata;
            held_err   = resp_error;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_error", 32'(resp_error), 32'(e.err));
                check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end else if (resp_valid && seen) begin
            check("hold_rdata", resp_rdata, held_rdata);
            check("hold_error", 32'(resp_error), 32'(held_err));
            check("busy_req_ready", 32'(req_ready), 32'd0);
        end
        if (!resp_valid) seen = 1'b0;
    end

    task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata);
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
    endtask

    // Present a request, wait for acceptance, queue the expected response.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata, input logic expect_resp,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        int n = 0;
        @(negedge clk);
        drive(we, addr, size, sgn, wdata);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (expect_resp) begin
            exp_t e;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.acc   = cyc;
            e.lat   = exp_lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 50), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) ram[i] = 32'(i);
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_write_en", 32'(mem_write_en), 32'd0);
        check("rst_mem_write_data", mem_write_data, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        // Word load, no write.
        w0 = n_writes;
        issue(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0000_0005, 1'b0, 2);
        drain();
        check("load_no_write", 32'(n_writes - w0), 32'd0);

        // Byte store RMW into word 3.
        w0 = n_writes;
        issue(1'b1, 32'h0D, 2'b00, 1'b0, 32'h0000_00AB, 1'b1, 32'h0, 1'b0, 3);
        drain();
        check("sb_write_count", 32'(n_writes - w0), 32'd1);
        check("sb_write_addr", last_waddr, 32'd3);
        check("sb_write_data", last_wdata, 32'h0000_AB03);
        issue(1'b0, 32'h0D, 2'b00, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFAB, 1'b0, 2);
        issue(1'b0, 32'h0D, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_00AB, 1'b0, 2);

        // Half store, word store, and reads back.
        issue(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_1234, 1'b1, 32'h0, 1'b0, 3);
        issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1'b1, 32'h1234_0008, 1'b0, 2);
        issue(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, 1'b1, 32'h0000_1234, 1'b0, 2);
        issue(1'b1, 32'h3FC, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 2);
        issue(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
        issue(1'b0, 32'h3FE, 2'b01, 1'b1, 32'h0, 1'b1, 32'hFFFF_DEAD, 1'b0, 2);
        issue(1'b0, 32'h3FD, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_00BE, 1'b0, 2);
        drain();

        // Error cases: never touch memory.
        w0 = n_writes;
        issue(1'b0, 32'h03, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 32'h06, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b1, 32'h400, 2'b10, 1'b0, 32'h5555_5555, 1'b1, 32'h0, 1'b1, 1);
        issue(1'b1, 32'h0002_0000, 2'b00, 1'b0, 32'h66, 1'b1, 32'h0, 1'b1, 1);
        drain();
        check("err_no_write", 32'(n_writes - w0), 32'd0);

        // Backpressure: response held, next request waits.
        resp_ready = 1'b0;
        issue(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0000_0005, 1'b0, 2);
        drive(1'b0, 32'h0C, 2'b00, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        check("bp_resp_valid", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        issue(1'b0, 32'h0C, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0000_0003, 1'b0, 2);
        drain();

        // Reset while the byte store is still reading: word must stay intact.
        w0 = n_writes;
        issue(1'b1, 32'h10, 2'b00, 1'b0, 32'h77, 1'b0, 32'h0, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        check("rst_read_we", 32'(mem_write_en), 32'd0);
        check("rst_read_ready", 32'(req_ready), 32'd1);
        check("rst_read_valid", 32'(resp_valid), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_read_no_write", 32'(n_writes - w0), 32'd0);
        check("rst_read_ram4", ram[4], 32'd4);
        issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b0, 2);
        drain();

        // Reset during the strobe cycle: strobe drops asynchronously.
        issue(1'b1, 32'h14, 2'b00, 1'b0, 32'h99, 1'b0, 32'h0, 1'b0, 0);
        @(posedge clk);
        #1;
        check("write_cycle_we", 32'(mem_write_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_write_we", 32'(mem_write_en), 32'd0);
        check("rst_write_ready", 32'(req_ready), 32'd1);
        check("rst_write_valid", 32'(resp_valid), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_write_no_resp", 32'(resp_valid), 32'd0);
        issue(1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
